sos_cascade_sequencer: RTL and testbench
========================================

SOS_CASCADE_SEQUENCER -- requirements
Module: sos_cascade_sequencer

Interface
REQ-001 SHALL have parameter NUM_SEC, default 4, number of second-order sections time-multiplexed on one biquad datapath.
REQ-002 SHALL have parameter WI_IN, default 8, sample integer bits.
REQ-003 SHALL have parameter WF_IN, default 18, sample fraction bits; W = WI_IN+WF_IN.
REQ-004 SHALL have parameter TIMEOUT, default 16, maximum WAIT cycles per section.
REQ-005 Port CLK, input, 1: single clock, rising edge.
REQ-006 Port Reset, input, 1: synchronous, active-high.
REQ-007 Port CE, input, 1: clock enable; low freezes all state.
REQ-008 Port in_valid / in_ready, input / output, 1 each: input sample handshake.
REQ-009 Port in_sample, input, W: signed fixed-point input sample.
REQ-010 Port bq_start, output, 1: one-cycle start pulse to the biquad datapath.
REQ-011 Port bq_sec, output, clog2(NUM_SEC): section index, selects coefficient set and state bank.
REQ-012 Port bq_x, output, W: section input sample.
REQ-013 Port bq_done, input, 1: datapath result-valid pulse.
REQ-014 Port bq_y, input, W: section output, already scaled and truncated to W.
REQ-015 Port bq_ovf, input, 1: datapath overflow for this section.
REQ-016 Port out_valid / out_ready, output / input, 1 each: output handshake.
REQ-017 Port out_sample, output, W: cascade result.
REQ-018 Port out_ovf, output, 1: overflow in any section of this sample.
REQ-019 Port overFlow, output, 1: sticky overflow.
REQ-020 Port err_timeout, output, 1: sticky watchdog error.
REQ-021 Port err_proto, output, 1: sticky error for an unexpected bq_done.
REQ-022 Port clr_err, input, 1: clears overFlow, err_timeout and err_proto.

Function
REQ-023 The FSM SHALL have states IDLE, ISSUE, WAIT and OUT; all transitions are registered, and only when CE=1.
REQ-024 In IDLE: in_ready=1.
- On in_valid&in_ready: capture in_sample into x_reg, set sec=0, clear ovf_acc, go to ISSUE.
REQ-025 In ISSUE: drive bq_start=1 for exactly one cycle with bq_sec=sec and bq_x=x_reg, clear the watchdog, go to WAIT.
REQ-026 In WAIT, on bq_done:
- x_reg<=bq_y and ovf_acc<=ovf_acc|bq_ovf.
- If sec==NUM_SEC-1, go to OUT; otherwise increment sec and go to ISSUE.
REQ-027 In WAIT, the watchdog SHALL count cycles without bq_done.
- If the count reaches TIMEOUT-1 with no done, set err_timeout, discard the sample and go to IDLE.
- No out_valid is produced for a discarded sample.
REQ-028 In OUT: out_valid=1, out_sample=x_reg, out_ovf=ovf_acc, all held stable until out_ready; on out_valid&out_ready go to IDLE.
REQ-029 Latency: with the accept in cycle 0 and bq_done arriving D>=1 cycles after each bq_start:
- Section k starts in cycle 1+k(D+1).
- out_valid first asserts in cycle NUM_SEC(D+1)+1.
REQ-030 in_ready SHALL be 0 in every state except IDLE; a new sample is never accepted while one is in flight.
REQ-031 bq_done in any state other than WAIT SHALL set err_proto and otherwise be ignored.
REQ-032 bq_done coincident with the watchdog's terminal count SHALL count as done; there is no timeout in that case.
REQ-033 overFlow SHALL be set on an OUT handshake with out_ovf=1.
REQ-034 clr_err SHALL clear the sticky flags unless a set condition occurs in the same cycle, in which case set wins.
REQ-035 CE=0 SHALL hold FSM, sec, x_reg, watchdog and outputs, and force bq_start=0.
- The datapath shares CE and does not pulse bq_done while CE=0.
REQ-036 bq_sec and bq_x SHALL be stable from ISSUE through the end of WAIT.

Reset
REQ-037 On Reset=1 at a CLK edge, regardless of CE:
- FSM goes to IDLE; sec=0 and x_reg=0; watchdog=0.
- bq_start=0, out_valid=0, out_sample=0, out_ovf=0.
- overFlow=0, err_timeout=0, err_proto=0.
REQ-038 in_ready SHALL read 0 while Reset=1 and 1 in the first cycle after Reset deasserts.
REQ-039 Reset mid-operation SHALL abandon the in-flight sample with no output; Reset also drives the datapath reset, which clears the section state banks.

Structure
REQ-040 Package sos_seq_pkg SHALL hold the FSM state encoding, the default NUM_SEC/WI_IN/WF_IN/TIMEOUT, and the section-index width function.
REQ-041 The watchdog counter SHALL be the sub-module sos_seq_watchdog, with ports clear, enable (CE and WAIT) and expired.

Verification
REQ-042 NUM_SEC=4, D=3, in_sample=0x0400000, bq_y=bq_x+1 -> bq_sec 0,1,2,3; out_valid in cycle 17; out_sample=0x0400004; out_ovf=0.
REQ-043 out_ready held low for 5 cycles in OUT -> out_sample stable throughout, in_ready=0, second in_valid not accepted until one cycle after the handshake.
REQ-044 bq_ovf=1 on section 2 only -> out_ovf=1, overFlow=1 after the handshake; clr_err pulse -> overFlow=0.
REQ-045 bq_done withheld on section 1 -> err_timeout=1 after 16 WAIT cycles, return to IDLE, no out_valid.
REQ-046 Reset asserted during section 2 WAIT -> next cycle IDLE, all outputs at reset values.
REQ-047 CE low for 4 cycles during ISSUE -> bq_start occurs exactly once, when CE returns; total latency increases by exactly 4.
REQ-048 Spurious bq_done in IDLE -> err_proto=1, no state change.

Source files
------------

// File: rtl/sos_cascade_sequencer_pkg.sv
// Shared types and defaults for the SOS cascade sequencer: FSM encoding,
// default geometry and the index-width helper.
package sos_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      OUT   = 2'd3
   } seq_state_t;

   localparam int DEF_NUM_SEC = 4;
   localparam int DEF_WI_IN   = 8;
   localparam int DEF_WF_IN   = 18;
   localparam int DEF_TIMEOUT = 16;

   // Never returns zero so single-entry indices still get a real bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sos_cascade_sequencer_if.sv
// Sample-in, biquad-datapath and sample-out signals of the cascade sequencer.
// The master modport is the sequencer; slave is the surrounding system.
interface sos_cascade_sequencer_if #(
   parameter int W  = 26,
   parameter int SW = 2
);
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_sample;

   logic          bq_start;
   logic [SW-1:0] bq_sec;
   logic [W-1:0]  bq_x;
   logic          bq_done;
   logic [W-1:0]  bq_y;
   logic          bq_ovf;

   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_sample;
   logic          out_ovf;

   modport master (
      input  in_valid, in_sample, bq_done, bq_y, bq_ovf, out_ready,
      output in_ready, bq_start, bq_sec, bq_x, out_valid, out_sample, out_ovf
   );

   modport slave (
      output in_valid, in_sample, bq_done, bq_y, bq_ovf, out_ready,
      input  in_ready, bq_start, bq_sec, bq_x, out_valid, out_sample, out_ovf
   );
endinterface

// File: rtl/sos_cascade_sequencer_watchdog.sv
// Per-section watchdog: counts enabled cycles and flags the terminal count.
module sos_seq_watchdog
   import sos_seq_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic CLK,
   input  logic Reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int CW = idx_width(TIMEOUT);

   logic [CW-1:0] count_reg;

   assign expired = enable && (count_reg == CW'(TIMEOUT - 1));

   always_ff @(posedge CLK) begin
      if (Reset) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (enable && !expired) begin
         count_reg <= count_reg + CW'(1);
      end
   end
endmodule

// File: rtl/sos_cascade_sequencer.sv
// Runs one input sample through NUM_SEC second-order sections on a shared
// biquad datapath, then presents the cascade result with overflow status.
module sos_cascade_sequencer
   import sos_seq_pkg::*;
#(
   parameter int NUM_SEC = DEF_NUM_SEC,
   parameter int WI_IN   = DEF_WI_IN,
   parameter int WF_IN   = DEF_WF_IN,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic CLK,
   input  logic Reset,
   input  logic CE,
   input  logic clr_err,
   sos_cascade_sequencer_if.master bus,
   output logic overFlow,
   output logic err_timeout,
   output logic err_proto
);
   localparam int W  = WI_IN + WF_IN;
   localparam int SW = idx_width(NUM_SEC);

   seq_state_t    state_reg, state_next;
   logic [SW-1:0] sec_reg, sec_next;
   logic [W-1:0]  x_reg, x_next;
   logic          ovf_acc_reg, ovf_acc_next;
   logic          wd_expired;
   logic          set_ovf, set_timeout, set_proto;

   sos_seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .CLK     (CLK),
      .Reset   (Reset),
      .clear   (CE && state_reg == ISSUE),
      .enable  (CE && state_reg == WAIT),
      .expired (wd_expired)
   );

   always_comb begin
      state_next   = state_reg;
      sec_next     = sec_reg;
      x_next       = x_reg;
      ovf_acc_next = ovf_acc_reg;
      set_ovf      = 1'b0;
      set_timeout  = 1'b0;
      set_proto    = bus.bq_done && (state_reg != WAIT);
      case (state_reg)
         IDLE: begin
            if (bus.in_valid) begin
               x_next       = bus.in_sample;
               sec_next     = '0;
               ovf_acc_next = 1'b0;
               state_next   = ISSUE;
            end
         end
         ISSUE: state_next = WAIT;
         WAIT: begin
            // A done on the terminal watchdog count still wins.
            if (bus.bq_done) begin
               x_next       = bus.bq_y;
               ovf_acc_next = ovf_acc_reg | bus.bq_ovf;
               if (sec_reg == SW'(NUM_SEC - 1)) begin
                  state_next = OUT;
               end else begin
                  sec_next   = sec_reg + SW'(1);
                  state_next = ISSUE;
               end
            end else if (wd_expired) begin
               set_timeout = 1'b1;
               state_next  = IDLE;
            end
         end
         OUT: begin
            if (bus.out_ready) begin
               set_ovf    = ovf_acc_reg;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_reg   <= IDLE;
         sec_reg     <= '0;
         x_reg       <= '0;
         ovf_acc_reg <= 1'b0;
         overFlow    <= 1'b0;
         err_timeout <= 1'b0;
         err_proto   <= 1'b0;
      end else if (CE) begin
         state_reg   <= state_next;
         sec_reg     <= sec_next;
         x_reg       <= x_next;
         ovf_acc_reg <= ovf_acc_next;
         overFlow    <= set_ovf     | (overFlow    & ~clr_err);
         err_timeout <= set_timeout | (err_timeout & ~clr_err);
         err_proto   <= set_proto   | (err_proto   & ~clr_err);
      end
   end

   assign bus.in_ready   = (state_reg == IDLE) && !Reset;
   assign bus.bq_start   = (state_reg == ISSUE) && CE;
   assign bus.bq_sec     = sec_reg;
   assign bus.bq_x       = x_reg;
   assign bus.out_valid  = (state_reg == OUT);
   assign bus.out_sample = x_reg;
   assign bus.out_ovf    = ovf_acc_reg;
endmodule

// File: tb/tb_sos_cascade_sequencer.sv
// Directed bench: table of samples through a behavioural datapath with
// y = x + 1 per section, plus hand-written corner-case sequences.
module tb_sos_cascade_sequencer;
   import sos_seq_pkg::*;

   localparam int NUM_SEC = 4;
   localparam int W       = 26;
   localparam int SW      = 2;

   logic CLK = 1'b0;
   logic Reset = 1'b1;
   logic CE = 1'b1;
   logic clr_err = 1'b0;
   logic overFlow, err_timeout, err_proto;

   sos_cascade_sequencer_if #(.W(W), .SW(SW)) bus ();

   sos_cascade_sequencer #(
      .NUM_SEC(NUM_SEC), .WI_IN(8), .WF_IN(18), .TIMEOUT(16)
   ) dut (
      .CLK         (CLK),
      .Reset       (Reset),
      .CE          (CE),
      .clr_err     (clr_err),
      .bus         (bus),
      .overFlow    (overFlow),
      .err_timeout (err_timeout),
      .err_proto   (err_proto)
   );

   always #5 CLK = ~CLK;

   // Behavioural datapath
   logic         resp_done = 1'b0;
   logic         resp_ovf  = 1'b0;
   logic         spur_done = 1'b0;
   logic [W-1:0] resp_y    = '0;
   logic [W-1:0] x_hold    = '0;
   int dly = 3, ovf_sec = -1, hold_sec = -1, rem = 0, nstarts = 0, sec_hold = 0;
   int start_cyc[16];
   int start_sec[16];
   int cyc = 0;

   assign bus.bq_done = resp_done | spur_done;
   assign bus.bq_y    = resp_y;
   assign bus.bq_ovf  = resp_ovf;

   initial forever begin
      @(posedge CLK);
      cyc++;
   end

   initial forever begin
      @(negedge CLK);
      resp_done = 1'b0;
      resp_ovf  = 1'b0;
      if (Reset) begin
         rem = 0;
      end else if (CE) begin
         if (rem > 0) begin
            rem--;
            if (rem == 0 && sec_hold != hold_sec) begin
               resp_done = 1'b1;
               resp_y    = x_hold + W'(1);
               resp_ovf  = (sec_hold == ovf_sec);
            end
         end
         if (bus.bq_start) begin
            rem      = dly;
            x_hold   = bus.bq_x;
            sec_hold = int'(bus.bq_sec);
            if (nstarts < 16) begin
               start_cyc[nstarts] = cyc;
               start_sec[nstarts] = sec_hold;
            end
            nstarts++;
         end
      end
   end

   int n_pass = 0, n_total = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send(input logic [W-1:0] x, input int d, input int osec, input int hsec,
                       output int a);
      dly = d; ovf_sec = osec; hold_sec = hsec; nstarts = 0;
      bus.in_sample = x;
      bus.in_valid  = 1'b1;
      chk("in_ready_idle", bus.in_ready, 1);
      a = cyc;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(input int a, output int lat);
      int n = 0;
      while (!bus.out_valid && n < 400) begin
         tick();
         n++;
      end
      if (!bus.out_valid) begin
         n_total++;
         $display("FAIL out_valid_wait: got 0 expected 1 within 400 cycles");
      end
      lat = cyc - a;
   endtask

   task automatic handshake();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic check_starts(input int base, input int d);
      logic ok = 1'b1;
      chk("start_count", nstarts, NUM_SEC);
      for (int k = 0; k < NUM_SEC; k++)
         if (start_cyc[k] != base + 1 + k * (d + 1) || start_sec[k] != k) ok = 1'b0;
      chk("start_schedule", ok, 1);
   endtask

   typedef struct {
      logic [W-1:0] x;
      int           d;
      int           ovf_sec;
      logic [W-1:0] exp_y;
      logic         exp_ovf;
      int           exp_lat;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int a, a2, lat;
      logic [W-1:0] held;
      logic seen;

      vecs[0] = '{26'h0400000, 3, -1, 26'h0400004, 1'b0, 17};
      vecs[1] = '{26'h0000000, 1, -1, 26'h0000004, 1'b0, 9};
      vecs[2] = '{26'h3FFFFFE, 2, -1, 26'h0000002, 1'b0, 13};
      vecs[3] = '{26'h1234567, 16, -1, 26'h123456B, 1'b0, 69};
      vecs[4] = '{26'h0400000, 3, 2, 26'h0400004, 1'b1, 17};

      bus.in_valid = 1'b0; bus.in_sample = '0; bus.out_ready = 1'b0;
      repeat (3) tick();
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_bq_start", bus.bq_start, 0);
      chk("rst_out_sample", bus.out_sample, 0);
      chk("rst_flags", {overFlow, err_timeout, err_proto}, 3'b000);
      Reset = 1'b0;
      #1;
      chk("post_rst_in_ready", bus.in_ready, 1);

      for (int i = 0; i < 5; i++) begin
         send(vecs[i].x, vecs[i].d, vecs[i].ovf_sec, -1, a);
         wait_out(a, lat);
         chk("latency", lat, vecs[i].exp_lat);
         chk("out_sample", bus.out_sample, vecs[i].exp_y);
         chk("out_ovf", bus.out_ovf, vecs[i].exp_ovf);
         check_starts(a, vecs[i].d);
         $display("vec %0d x=%h d=%0d y=%h ovf=%0d lat=%0d", i, vecs[i].x, vecs[i].d,
                  bus.out_sample, bus.out_ovf, lat);
         handshake();
         chk("post_hs_out_valid", bus.out_valid, 0);
         chk("post_hs_in_ready", bus.in_ready, 1);
         chk("no_timeout", err_timeout, 0);
         chk("overflow_sticky", overFlow, vecs[i].exp_ovf);
      end
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("overflow_cleared", overFlow, 0);

      // Backpressure: output held, second sample waits for the handshake
      send(26'h0000100, 1, -1, -1, a);
      wait_out(a, lat);
      chk("bp_latency", lat, 9);
      held = bus.out_sample;
      bus.in_sample = 26'h0000200;
      bus.in_valid  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_out_stable", bus.out_sample, held);
         chk("bp_out_valid", bus.out_valid, 1);
         chk("bp_in_ready", bus.in_ready, 0);
      end
      handshake();
      chk("bp_idle_in_ready", bus.in_ready, 1);
      chk("bp_idle_out_valid", bus.out_valid, 0);
      a2 = cyc;
      tick();
      bus.in_valid = 1'b0;
      chk("bp_second_busy", bus.in_ready, 0);
      chk("bp_second_start", bus.bq_start, 1);
      chk("bp_second_x", bus.bq_x, 26'h0000200);
      wait_out(a2, lat);
      chk("bp_second_y", bus.out_sample, 26'h0000204);
      $display("backpressure second sample y=%h lat=%0d", bus.out_sample, lat);
      handshake();

      // Spurious done in IDLE, then set-wins-over-clear
      spur_done = 1'b1;
      tick();
      spur_done = 1'b0;
      chk("spur_err_proto", err_proto, 1);
      chk("spur_still_idle", bus.in_ready, 1);
      chk("spur_no_out", bus.out_valid, 0);
      spur_done = 1'b1; clr_err = 1'b1;
      tick();
      spur_done = 1'b0; clr_err = 1'b0;
      chk("spur_set_wins", err_proto, 1);
      $display("spurious bq_done err_proto=%0d", err_proto);

      // Reset during section 2 WAIT
      send(26'h0400000, 3, -1, -1, a);
      repeat (9) tick();
      chk("mid_busy", bus.in_ready, 0);
      Reset = 1'b1;
      tick();
      chk("mid_rst_in_ready", bus.in_ready, 0);
      chk("mid_rst_out_valid", bus.out_valid, 0);
      chk("mid_rst_bq_start", bus.bq_start, 0);
      chk("mid_rst_out_sample", bus.out_sample, 0);
      chk("mid_rst_out_ovf", bus.out_ovf, 0);
      chk("mid_rst_flags", {overFlow, err_timeout, err_proto}, 3'b000);
      Reset = 1'b0;
      #1;
      chk("mid_rst_release", bus.in_ready, 1);
      seen = 1'b0;
      repeat (20) begin
         tick();
         if (bus.out_valid) seen = 1'b1;
      end
      chk("mid_rst_no_output", seen, 0);
      $display("reset mid-operation abandoned sample");

      // Watchdog: section 1 never completes
      send(26'h0000010, 3, -1, 1, a);
      seen = 1'b0;
      repeat (20) begin
         tick();
         if (bus.out_valid) seen = 1'b1;
      end
      chk("wd_not_yet", err_timeout, 0);
      chk("wd_still_busy", bus.in_ready, 0);
      tick();
      chk("wd_err_timeout", err_timeout, 1);
      chk("wd_back_idle", bus.in_ready, 1);
      chk("wd_no_output", seen | bus.out_valid, 0);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("wd_cleared", err_timeout, 0);
      $display("watchdog timeout err_timeout set and cleared");

      // CE low for 4 cycles during ISSUE
      send(26'h0000020, 3, -1, -1, a);
      CE = 1'b0;
      #1;
      chk("ce_hold_start", bus.bq_start, 0);
      repeat (3) begin
         tick();
         chk("ce_hold_start", bus.bq_start, 0);
      end
      tick();
      CE = 1'b1;
      #1;
      chk("ce_resume_start", bus.bq_start, 1);
      wait_out(a, lat);
      chk("ce_latency", lat, 21);
      chk("ce_out_sample", bus.out_sample, 26'h0000024);
      check_starts(a + 4, 3);
      $display("clock-enable stall y=%h lat=%0d", bus.out_sample, lat);
      handshake();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
